// File: rtl/outcnt_drive_sched_if.sv
// Handshake between the drive scheduler and the counter priority logic:
// one-hot DINC request out, active-low POUT/MOUT/ZOUT responses back.
interface outcnt_drive_sched_if #(
  parameter int unsigned N_REQ = 8
);
  logic [N_REQ-1:0] dinc;
  logic             POUT_;
  logic             MOUT_;
  logic             ZOUT_;

  modport master (
    output dinc,
    input  POUT_,
    input  MOUT_,
    input  ZOUT_
  );

  modport slave (
    input  dinc,
    output POUT_,
    output MOUT_,
    output ZOUT_
  );
endinterface

// File: rtl/outcnt_drive_sched.sv
// Round-robin scheduler for the shared output-counter drive slot: grants one
// pending requester a DINC per counter slot and turns the response into a drive pulse.
module outcnt_drive_sched #(
  parameter int unsigned N_REQ    = 8,
  parameter int unsigned PULSE_W  = 4,
  parameter int unsigned TO_SLOTS = 3
) (
  input  logic                 prop_clk,
  input  logic                 rst,
  input  logic                 rate_tick,
  input  logic                 slot,
  input  logic [N_REQ-1:0]     enab,
  outcnt_drive_sched_if.master cnt,
  output logic [N_REQ-1:0]     drv_p,
  output logic [N_REQ-1:0]     drv_m,
  output logic [N_REQ-1:0]     done,
  output logic                 busy,
  output logic                 tmo_err
);

  localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef logic [IdxW-1:0] idx_t;
  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e           state_q;
  idx_t             ptr_q;
  idx_t             gnt_q;
  logic [2:0]       slot_cnt_q;
  logic [N_REQ-1:0] pend_q, pend_d;
  logic [N_REQ-1:0] dinc_q;
  logic [N_REQ-1:0] done_q;
  logic [N_REQ-1:0] drv_p_q;
  logic [N_REQ-1:0] drv_m_q;
  logic [3:0]       wcnt_q [N_REQ];
  logic             busy_q;
  logic             tmo_q;

  logic             srch_hit;
  idx_t             srch_idx;
  idx_t             cand;
  logic             wait_st;
  logic             rsp_z, rsp_p, rsp_m, rsp_any;
  logic             grant;
  logic             tmo_hit;

  // First pending index after the last grant, wrapping modulo N_REQ.
  always_comb begin
    srch_hit = 1'b0;
    srch_idx = ptr_q;
    cand     = ptr_q;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = idx_t'((32'(ptr_q) + k) % N_REQ);
      if (!srch_hit && pend_q[cand]) begin
        srch_hit = 1'b1;
        srch_idx = cand;
      end
    end
  end

  // Response priority ZOUT_ > POUT_ > MOUT_, only looked at while waiting.
  always_comb begin
    wait_st = (state_q == StWait);
    rsp_z   = wait_st & ~cnt.ZOUT_;
    rsp_p   = wait_st & cnt.ZOUT_ & ~cnt.POUT_;
    rsp_m   = wait_st & cnt.ZOUT_ & cnt.POUT_ & ~cnt.MOUT_;
    rsp_any = rsp_z | rsp_p | rsp_m;
    grant   = (state_q == StIdle) & slot & srch_hit;
    tmo_hit = wait_st & ~rsp_any & slot & (slot_cnt_q == 3'(TO_SLOTS - 1));
  end

  // A rate tick in the grant clock re-arms the request so the tick is not lost.
  always_comb begin
    pend_d = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      pend_d[i] = enab[i] & (rate_tick | (pend_q[i] & ~(grant && (srch_idx == idx_t'(i)))));
    end
  end

  always_ff @(posedge prop_clk or negedge rst) begin
    if (!rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  always_ff @(posedge prop_clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      ptr_q      <= idx_t'(N_REQ - 1);
      gnt_q      <= '0;
      slot_cnt_q <= '0;
      dinc_q     <= '0;
      done_q     <= '0;
      busy_q     <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      done_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (grant) begin
            gnt_q      <= srch_idx;
            dinc_q     <= N_REQ'(1) << srch_idx;
            busy_q     <= 1'b1;
            slot_cnt_q <= '0;
            state_q    <= StWait;
          end
        end
        StWait: begin
          if (rsp_any || tmo_hit) begin
            if (rsp_z) begin
              done_q <= N_REQ'(1) << gnt_q;
            end
            if (tmo_hit) begin
              tmo_q <= 1'b1;
            end
            dinc_q  <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= gnt_q;
            state_q <= StIdle;
          end else if (slot) begin
            slot_cnt_q <= slot_cnt_q + 3'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Per-requester pulse stretcher; a new response restarts width and direction.
  always_ff @(posedge prop_clk or negedge rst) begin
    if (!rst) begin
      drv_p_q <= '0;
      drv_m_q <= '0;
      for (int i = 0; i < int'(N_REQ); i++) begin
        wcnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(N_REQ); i++) begin
        if ((rsp_p || rsp_m) && (gnt_q == idx_t'(i))) begin
          wcnt_q[i]  <= 4'(PULSE_W);
          drv_p_q[i] <= rsp_p;
          drv_m_q[i] <= rsp_m;
        end else if (wcnt_q[i] != 4'd0) begin
          wcnt_q[i] <= wcnt_q[i] - 4'd1;
          if (wcnt_q[i] == 4'd1) begin
            drv_p_q[i] <= 1'b0;
            drv_m_q[i] <= 1'b0;
          end
        end
      end
    end
  end

  assign cnt.dinc = dinc_q;
  assign drv_p    = drv_p_q;
  assign drv_m    = drv_m_q;
  assign done     = done_q;
  assign busy     = busy_q;
  assign tmo_err  = tmo_q;

  a_dinc_onehot: assert property (@(posedge prop_clk) disable iff (!rst) $onehot0(dinc_q));
  a_drv_excl: assert property (@(posedge prop_clk) disable iff (!rst) ((drv_p_q & drv_m_q) == '0));

endmodule

// File: doc/outcnt_drive_sched.md
# outcnt_drive_sched

Round-robin scheduler for the output-counter drive slot shared by the channel-14 drive outputs (CDU X/Y/Z, trunnion, shaft, thrust, EMS, gyro). Each enabled output accumulates drive requests at the drive rate. Once per memory-cycle counter slot, the scheduler grants one requester a DINC request to the counter priority logic. It then converts the counter's POUT/MOUT/ZOUT response into a timed plus/minus drive pulse, or into a done indication that the enable bit can be cleared. It sits between the channel-14 output register and the counter-increment sequencer.

## Interface
- N_REQ, 8, number of drive requesters; index 0 has first grant after reset
- PULSE_W, 4, drive-pulse width in clocks, 1..15
- TO_SLOTS, 3, counter slots waited for a response before timeout, 1..7
- prop_clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- rate_tick  in  1  drive-rate strobe, one clock wide
- slot  in  1  counter-slot strobe, one clock wide, at most one per 2 clocks
- enab  in  N_REQ  channel-14 drive enable bits, level
- POUT_  in  1  counter response: plus pulse, active-low, sampled only in WAIT
- MOUT_  in  1  counter response: minus pulse, active-low, sampled only in WAIT
- ZOUT_  in  1  counter response: counter reached zero, active-low, sampled only in WAIT
- dinc  out  N_REQ  one-hot DINC request, held for the whole WAIT
- drv_p  out  N_REQ  plus drive pulse, PULSE_W clocks
- drv_m  out  N_REQ  minus drive pulse, PULSE_W clocks
- done  out  N_REQ  one-clock pulse, counter of that requester reached zero
- busy  out  1  high in WAIT
- tmo_err  out  1  sticky timeout flag, cleared only by reset

## Operation
- Pending register pend[N_REQ]:
  - pend[i] is set on rate_tick when enab[i]=1.
  - pend[i] is cleared when requester i is granted.
  - pend[i] is cleared on any clock with enab[i]=0.
  - Set and grant-clear in the same clock: set wins, so the tick is not lost.
- Pointer ptr holds the last-granted index.
  - The grant search order is ptr+1, ptr+2, … modulo N_REQ.
- FSM states are IDLE and WAIT.
- IDLE:
  - On slot with any pend bit set, grant g = the first pending index in search order.
  - Clear pend[g], latch g, enter WAIT, zero the slot counter.
  - slot with no pend bit set: stay in IDLE.
- WAIT:
  - dinc[g]=1 and busy=1.
  - Each clock, sample the responses with priority ZOUT_ > POUT_ > MOUT_; lower-priority responses in the same clock are ignored.
  - ZOUT_ low: done[g] pulses; no drive pulse.
  - POUT_ low: drv_p[g] pulses for PULSE_W clocks.
  - MOUT_ low: drv_m[g] pulses for PULSE_W clocks.
  - Any accepted response: ptr=g, return to IDLE.
  - Each slot without a response increments the slot counter.
  - Slot counter reaching TO_SLOTS: set tmo_err, drop dinc, ptr=g, return to IDLE; no drive and no done.
  - enab[g] falling during WAIT does not abort; the response is still honoured.
- Drive pulses:
  - One 4-bit width counter per requester.
  - A new pulse on a requester whose pulse is still active restarts the width; the newest direction wins.
  - drv_p[i] and drv_m[i] are never high together.

## Timing
- Reset: dinc=0, drv_p=0, drv_m=0, done=0, busy=0, tmo_err=0, pend=0, FSM=IDLE, ptr=N_REQ-1, width counters=0.
- Grant:
  - Evaluated on the clock edge where slot=1.
  - dinc and busy go high after that edge.
- Response:
  - Accepted on the edge where the input is low in WAIT.
  - dinc drops after that edge.
  - drv_*/done rise after the same edge, so response-to-drive latency is 1 clock.
- Earliest next grant is the next slot after returning to IDLE.
  - A slot coinciding with the response edge is not used for a grant.
- Timeout: dinc drops after the edge of the TO_SLOTS-th slot counted in WAIT.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, enab=0x01, rate_tick, slot, POUT_ low 2 clocks later -> dinc=0x01 for 2 clocks, then drv_p[0] high exactly 4 clocks, busy low.
- enab=0xFF, one rate_tick, 8 slots each answered by MOUT_ -> grant order 0..7, each drv_m pulse 4 clocks, pend=0 at end.
- Grant requester 3, ZOUT_ and POUT_ low in the same clock -> done[3] one clock, drv_p[3] stays 0.
- Grant requester 5, no response, 3 slots -> dinc drops after the third slot edge, tmo_err=1 and stays 1, next slot grants 6 if pending.
- enab[2] toggles 1->0 between rate_tick and slot -> pend[2] cleared, no dinc[2].
- rst asserted mid-WAIT while drv_p[1] active -> all outputs 0 immediately, ptr=7; after release the first grant goes to index 0.
